// File: rtl/fp16_pkg.sv
// Shared types and constants for the binary16 -> signed integer converter.
package fp16_pkg;
  localparam int FP16_BIAS   = 15;
  localparam int FP16_FRAC_W = 10;
  localparam int EXP_INF     = 31;
  // Exponent at which {1,fraction} is already an integer (no shift needed).
  localparam int SHIFT_ZERO  = FP16_BIAS + FP16_FRAC_W;
  // 11-bit mantissa plus at most five left shifts never exceeds 16 bits.
  localparam int MAG_W       = 16;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_PACK,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    CLS_NUM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;
endpackage

// File: rtl/fp2int_pack.sv
// Combinational round / negate / saturate stage used in the PACK state.
// Define FP2INT_ROUND_NEAREST_EN for round-to-nearest-even; default truncates toward zero.
module fp2int_pack
  import fp16_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             sign,
  input  fp_class_e        cls,
  input  logic [MAG_W-1:0] mag,
  input  logic             guard,
  input  logic             sticky,
  output logic [OUT_W-1:0] data,
  output logic             ovf,
  output logic             inexact
);
  localparam int W = ((MAG_W > OUT_W) ? MAG_W : OUT_W) + 1;
  localparam logic [W-1:0]     POS_LIM = W'({(OUT_W-1){1'b1}});
  localparam logic [W-1:0]     NEG_LIM = POS_LIM + W'(1);
  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  logic         round_up;
  logic [W-1:0] mag_r;
  logic [W-1:0] mag_n;

`ifdef FP2INT_ROUND_NEAREST_EN
  assign round_up = guard & (sticky | mag[0]);
`else
  assign round_up = 1'b0;
`endif

  // Rounding is applied to the magnitude, so a carry can still push it out of range.
  assign mag_r = W'(mag) + W'(round_up);
  assign mag_n = W'(0) - mag_r;

  always_comb begin
    data    = '0;
    ovf     = 1'b0;
    inexact = guard | sticky;
    unique case (cls)
      CLS_INF: begin
        data    = sign ? MIN_NEG : MAX_POS;
        ovf     = 1'b1;
        inexact = 1'b0;
      end
      CLS_NAN: begin
        data    = MAX_POS;
        ovf     = 1'b1;
        inexact = 1'b0;
      end
      default: begin
        if (!sign) begin
          if (mag_r > POS_LIM) begin
            data = MAX_POS;
            ovf  = 1'b1;
          end else begin
            data = mag_r[OUT_W-1:0];
          end
        end else begin
          if (mag_r > NEG_LIM) begin
            data = MIN_NEG;
            ovf  = 1'b1;
          end else begin
            data = mag_n[OUT_W-1:0];
          end
        end
      end
    endcase
  end
endmodule

// File: rtl/fp16_to_int.sv
// Sequential binary16 -> OUT_W-bit signed integer converter, one mantissa bit shift per cycle.
// Rounding mode selected by FP2INT_ROUND_NEAREST_EN (see fp2int_pack).
module fp16_to_int
  import fp16_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_inexact
);
  state_e                  state_q, state_d;
  logic                    sign_q;
  fp_class_e               cls_q;
  logic [MAG_W-1:0]        mag_q;
  logic                    guard_q, sticky_q, left_q;
  logic [CNT_W-1:0]        cnt_q;

  logic [4:0]              exp_f;
  logic [FP16_FRAC_W-1:0]  frac_f;
  logic                    accept, early, shift_last;
  logic [OUT_W-1:0]        pack_data;
  logic                    pack_ovf, pack_inexact;

  assign exp_f      = in_data[14:FP16_FRAC_W];
  assign frac_f     = in_data[FP16_FRAC_W-1:0];
  assign early      = (exp_f < 5'(FP16_BIAS)) || (exp_f == 5'(EXP_INF));
  assign accept     = in_valid && in_ready;
  // k = 0 still spends one SHIFT cycle, so leave on a count of 0 or 1.
  assign shift_last = (cnt_q <= CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = early ? S_PACK : S_SHIFT;
      end
      S_SHIFT: if (shift_last) state_d = S_PACK;
      S_PACK:  state_d = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q   <= 1'b0;
      cls_q    <= CLS_NUM;
      mag_q    <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      left_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (accept) begin
      sign_q  <= in_data[15];
      guard_q <= 1'b0;
      left_q  <= 1'b0;
      cnt_q   <= '0;
      if (exp_f == 5'(EXP_INF)) begin
        cls_q    <= (frac_f == '0) ? CLS_INF : CLS_NAN;
        mag_q    <= '0;
        sticky_q <= 1'b0;
      end else if (exp_f < 5'(FP16_BIAS)) begin
        // |x| < 1: result is zero, any nonzero bit is discarded.
        cls_q    <= CLS_NUM;
        mag_q    <= '0;
        sticky_q <= |in_data[14:0];
      end else begin
        cls_q    <= CLS_NUM;
        mag_q    <= MAG_W'({1'b1, frac_f});
        sticky_q <= 1'b0;
        if (exp_f >= 5'(SHIFT_ZERO)) begin
          left_q <= 1'b1;
          cnt_q  <= CNT_W'(exp_f - 5'(SHIFT_ZERO));
        end else begin
          cnt_q  <= CNT_W'(5'(SHIFT_ZERO) - exp_f);
        end
      end
    end else if (state_q == S_SHIFT && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (left_q) begin
        mag_q <= mag_q << 1;
      end else begin
        mag_q    <= mag_q >> 1;
        guard_q  <= mag_q[0];
        sticky_q <= sticky_q | guard_q;
      end
    end
  end

  fp2int_pack #(
    .OUT_W(OUT_W)
  ) u_pack (
    .sign    (sign_q),
    .cls     (cls_q),
    .mag     (mag_q),
    .guard   (guard_q),
    .sticky  (sticky_q),
    .data    (pack_data),
    .ovf     (pack_ovf),
    .inexact (pack_inexact)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data    <= '0;
      out_ovf     <= 1'b0;
      out_inexact <= 1'b0;
    end else if (state_q == S_PACK) begin
      out_data    <= pack_data;
      out_ovf     <= pack_ovf;
      out_inexact <= pack_inexact;
    end
  end
endmodule

// File: tb/tb_fp16_to_int.sv
// Scoreboard bench for fp16_to_int: directed corner cases plus randomized operands vs an arithmetic model.
module tb_fp16_to_int;
  localparam int OUT_W = 16;

  typedef struct {
    logic [15:0]      din;
    logic [OUT_W-1:0] data;
    logic             ovf;
    logic             inx;
    int               lat;
    int               acc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf;
  logic             out_inexact;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic stall = 1'b0;
  logic bp = 1'b0;
  exp_t sb[$];

  fp16_to_int #(.OUT_W(OUT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ovf     (out_ovf),
    .out_inexact (out_inexact)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (stall)   out_ready = 1'b0;
    else if (bp) out_ready = ($urandom_range(0, 3) != 0);
    else         out_ready = 1'b1;
  end

  // Reference: value*1024 is an exact integer for every finite exponent >= 15.
  function automatic exp_t model(input logic [15:0] d);
    exp_t   r;
    int     e;
    longint f, scaled, ip, fr, val;
    longint lim_p, lim_n;
    logic [63:0] v64;
    e     = int'(d[14:10]);
    f     = longint'(d[9:0]);
    lim_p = (longint'(1) <<< (OUT_W - 1)) - 1;
    lim_n = lim_p + 1;
    r.din = d;
    r.ovf = 1'b0;
    r.inx = 1'b0;
    r.acc = 0;
    if (e == 31) begin
      r.ovf = 1'b1;
      val   = (f != 0 || !d[15]) ? lim_p : -lim_n;
      r.lat = 2;
    end else if (e < 15) begin
      val   = 0;
      r.inx = (d[14:0] != 0);
      r.lat = 2;
    end else begin
      scaled = (1024 + f) <<< (e - 15);
      ip     = scaled >>> 10;
      fr     = scaled % 1024;
      r.inx  = (fr != 0);
`ifdef FP2INT_ROUND_NEAREST_EN
      if (fr > 512 || (fr == 512 && (ip % 2) == 1)) ip = ip + 1;
`endif
      if (d[15]) begin
        if (ip > lim_n) begin val = -lim_n; r.ovf = 1'b1; end
        else val = -ip;
      end else begin
        if (ip > lim_p) begin val = lim_p; r.ovf = 1'b1; end
        else val = ip;
      end
      r.lat = 2 + ((e == 25) ? 1 : ((e > 25) ? e - 25 : 25 - e));
    end
    v64    = val;
    r.data = v64[OUT_W-1:0];
    return r;
  endfunction

  function automatic exp_t mk(input logic [OUT_W-1:0] data, input logic ovf, input logic inx,
                              input int lat);
    exp_t r;
    r.din  = '0;
    r.data = data;
    r.ovf  = ovf;
    r.inx  = inx;
    r.lat  = lat;
    r.acc  = 0;
    return r;
  endfunction

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic send(input logic [15:0] d, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout din=%h got=no_accept want=accept", d);
      in_valid = 1'b0;
      return;
    end
    e.din = d;
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Monitor: checks latency on first valid cycle, stability while stalled, value on handshake.
  logic             have = 1'b0;
  logic [OUT_W-1:0] cap_data;
  logic             cap_ovf, cap_inx;
  always @(negedge clk) begin
    exp_t cur;
    if (rst) begin
      have = 1'b0;
    end else if (out_valid) begin
      if (!have) begin
        have     = 1'b1;
        cap_data = out_data;
        cap_ovf  = out_ovf;
        cap_inx  = out_inexact;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result got=%h want=none", out_data);
        end else begin
          cur = sb[0];
          check($sformatf("latency[%h]", cur.din), cyc - cur.acc, cur.lat);
        end
      end else begin
        check("stable_data", out_data, cap_data);
        check("stable_flags", {out_ovf, out_inexact}, {cap_ovf, cap_inx});
      end
      check("in_ready_in_done", in_ready, 0);
      if (out_ready) begin
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          check($sformatf("data[%h]", cur.din), out_data, cur.data);
          check($sformatf("ovf[%h]", cur.din), out_ovf, cur.ovf);
          check($sformatf("inexact[%h]", cur.din), out_inexact, cur.inx);
        end
        have = 1'b0;
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    logic [15:0] d;
    int          e, n;
    logic [OUT_W-1:0] half_val;

    #1 rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_flags", {out_ovf, out_inexact}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

`ifdef FP2INT_ROUND_NEAREST_EN
    half_val = 16'd2;
`else
    half_val = 16'd1;
`endif
    send(16'h3C00, mk(16'h0001, 1'b0, 1'b0, 12));
    send(16'hC500, mk(16'hFFFB, 1'b0, 1'b0, 10));
    send(16'h0000, mk(16'h0000, 1'b0, 1'b0, 2));
    send(16'h8000, mk(16'h0000, 1'b0, 1'b0, 2));
    send(16'h3E00, mk(half_val, 1'b0, 1'b1, 12));
    send(16'h4100, mk(16'h0002, 1'b0, 1'b1, 11));
    send(16'h3800, mk(16'h0000, 1'b0, 1'b1, 2));
    send(16'h6400, mk(16'h0400, 1'b0, 1'b0, 3));
    send(16'h7800, mk(16'h7FFF, 1'b1, 1'b0, 7));
    send(16'hF800, mk(16'h8000, 1'b0, 1'b0, 7));
    send(16'h7C00, mk(16'h7FFF, 1'b1, 1'b0, 2));
    send(16'hFC00, mk(16'h8000, 1'b1, 1'b0, 2));
    send(16'h7E00, mk(16'h7FFF, 1'b1, 1'b0, 2));
    drain();

    // Reset in the middle of a long shift sequence; previous result (0x7FFF, ovf) is still held.
    send(16'h3C00, mk(16'h0001, 1'b0, 1'b0, 12));
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_ovf", out_ovf, 0);
    check("midrst_inexact", out_inexact, 0);
    sb.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (20) @(negedge clk);
    send(16'h6400, mk(16'h0400, 1'b0, 1'b0, 3));
    drain();

    // Consumer stalls in DONE while a second operand is already offered.
    stall = 1'b1;
    send(16'hC500, mk(16'hFFFB, 1'b0, 1'b0, 10));
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_valid_seen", out_valid, 1);
    in_valid = 1'b1;
    in_data  = 16'h4100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_held", {out_valid, in_ready}, 2'b10);
    end
    stall = 1'b0;
    send(16'h4100, mk(16'h0002, 1'b0, 1'b1, 11));
    drain();

    bp = 1'b1;
    for (int i = 0; i < 80; i++) begin
      e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(15, 30));
      d = {1'($urandom_range(0, 1)), 5'(e), 10'($urandom_range(0, 1023))};
      send(d, model(d));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
